wb_queue: RTL and testbench
===========================

WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, 2..8).
REQ-002 SHALL have parameter DATA_W, default 16, register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  producer offers a write-back (reg, data).
REQ-006 SHALL have port in_ready  output  1  queue can accept an entry this cycle.
REQ-007 SHALL have port in_reg  input  4  destination register index.
REQ-008 SHALL have port in_data  input  DATA_W  destination data.
REQ-009 SHALL have port flush  input  1  synchronous discard of all pending entries.
REQ-010 SHALL have port rf_stall  input  1  register file write port unavailable this cycle.
REQ-011 SHALL have port rf_write_en  output  1  write strobe to register file (bit-cell WriteEnable via decoder).
REQ-012 SHALL have port rf_write_reg  output  4  register index being written.
REQ-013 SHALL have port rf_write_data  output  DATA_W  data driven onto bit-cell D inputs.
REQ-014 SHALL have ports rd_reg1, rd_reg2  input  4  register indices being read this cycle.
REQ-015 SHALL have ports byp_hit1, byp_hit2  output  1  pending entry matches the corresponding rd_reg.
REQ-016 SHALL have ports byp_data1, byp_data2  output  DATA_W  data of youngest matching pending entry.
REQ-017 SHALL have port count  output  log2(DEPTH)+1  number of valid entries, 0..DEPTH.

Function
REQ-018 SHALL be a circular FIFO with head/tail pointers wrapping modulo DEPTH; count tracks occupancy.
REQ-019 SHALL drive in_ready = (count != DEPTH), combinational from state only.
REQ-020 SHALL push on a rising edge where in_valid && in_ready && !flush.
REQ-021 SHALL accept but not enqueue entries with in_reg == 0 (register 0 hardwired zero); count unchanged by such a push.
REQ-022 SHALL drive rf_write_en = (count != 0) && !rf_stall && !flush, with rf_write_reg/rf_write_data from the head entry combinationally.
REQ-023 SHALL pop the head on the same rising edge that rf_write_en is high (register file captures the same edge).
REQ-024 SHALL drive rf_write_reg and rf_write_data to 0 whenever rf_write_en is 0.
REQ-025 SHALL keep count unchanged on simultaneous push and pop; empty-queue push-through latency is one cycle (visible at head the cycle after push).
REQ-026 SHALL, on flush, clear all entries and count to 0 on that edge; flush overrides push and pop.
REQ-027 SHALL not overflow: when full, in_valid is ignored; pop in the same cycle does not raise in_ready that cycle.
REQ-028 SHALL preserve order: writes to the same register reach the register file in push order.

Reset
REQ-029 SHALL, while rst is low, asynchronously clear pointers, count and all entry valid bits.
REQ-030 SHALL hold during reset: in_ready=1, rf_write_en=0, rf_write_reg=0, rf_write_data=0, byp_hit1/2=0, byp_data1/2=0, count=0.
REQ-031 SHALL discard all pending entries if reset asserts mid-operation; no partial write is issued after reset release.

Configuration
REQ-032 SHALL implement read bypass only when macro WB_BYPASS_EN is defined: byp_hitN=1 when any valid entry has reg == rd_regN and rd_regN != 0; byp_dataN = data of youngest such entry, else 0; combinational, includes the head entry being written this cycle.
REQ-033 SHALL, without WB_BYPASS_EN, tie byp_hit1/2 and byp_data1/2 to 0 and contain no comparator logic.

Verification
REQ-034 SHALL cover: reset release, push (reg 3, 0x1234) with rf_stall=0 -> next cycle rf_write_en=1, rf_write_reg=3, rf_write_data=0x1234, count returns 0 after that edge.
REQ-035 SHALL cover: rf_stall=1, push 4 entries -> count=4, in_ready=0; 5th in_valid ignored; release stall -> four writes in push order on four consecutive cycles.
REQ-036 SHALL cover: push (reg 0, 0xFFFF) -> count stays 0, rf_write_en never asserts.
REQ-037 SHALL cover (WB_BYPASS_EN): stall, push (5,0x0001) then (5,0x0002), rd_reg1=5 -> byp_hit1=1, byp_data1=0x0002; rd_reg2=0 -> byp_hit2=0.
REQ-038 SHALL cover: 3 entries pending, flush=1 with in_valid=1 -> count=0 next cycle, no rf_write_en that cycle or after.
REQ-039 SHALL cover: rst driven low between clock edges with 2 entries pending -> outputs reach reset values immediately, no write after rst returns high.

Source files
------------

// File: rtl/wb_queue.sv
// wb_queue: register-file write-back queue.
// Circular FIFO of (register index, data) pairs drained into the register
// file whenever its write port is free. Writes to register 0 are accepted
// but dropped. Optional read bypass over pending entries is enabled with
// the WB_BYPASS_EN macro.
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_reg,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   flush,
  input  logic                   rf_stall,
  output logic                   rf_write_en,
  output logic [3:0]             rf_write_reg,
  output logic [DATA_W-1:0]      rf_write_data,
  input  logic [3:0]             rd_reg1,
  input  logic [3:0]             rd_reg2,
  output logic                   byp_hit1,
  output logic                   byp_hit2,
  output logic [DATA_W-1:0]      byp_data1,
  output logic [DATA_W-1:0]      byp_data2,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     head_r;
  logic [PW-1:0]     tail_r;
  logic [CW-1:0]     count_r;
  logic [CW-1:0]     count_n;
  logic [3:0]        reg_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  valid_r;

  logic push_s;
  logic enq_s;
  logic pop_s;

  assign count    = count_r;
  assign in_ready = (count_r != CW'(DEPTH));
  // A register-0 push is handshaken but never stored.
  assign push_s   = in_valid && in_ready && !flush;
  assign enq_s    = push_s && (in_reg != 4'd0);
  // The register file captures on the same edge that the head is popped.
  assign rf_write_en   = (count_r != {CW{1'b0}}) && !rf_stall && !flush;
  assign pop_s         = rf_write_en;
  assign rf_write_reg  = rf_write_en ? reg_mem[head_r]  : 4'd0;
  assign rf_write_data = rf_write_en ? data_mem[head_r] : {DATA_W{1'b0}};

  // Next occupancy from enqueue/pop; simultaneous push and pop cancel.
  always_comb begin
    count_n = count_r;
    case ({enq_s, pop_s})
      2'b10:   count_n = count_r + CW'(1);
      2'b01:   count_n = count_r - CW'(1);
      default: count_n = count_r;
    endcase
  end

  // Queue storage, pointers and occupancy; flush discards everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      valid_r <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        reg_mem[i]  <= 4'd0;
        data_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (flush) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
      valid_r <= {DEPTH{1'b0}};
    end else begin
      if (enq_s) begin
        reg_mem[tail_r]  <= in_reg;
        data_mem[tail_r] <= in_data;
        valid_r[tail_r]  <= 1'b1;
        tail_r           <= tail_r + PW'(1);
      end
      if (pop_s) begin
        valid_r[head_r] <= 1'b0;
        head_r          <= head_r + PW'(1);
      end
      count_r <= count_n;
    end
  end

`ifdef WB_BYPASS_EN
  logic [PW-1:0] idx1_s;
  logic [PW-1:0] idx2_s;

  // Scan oldest to youngest so the last match found is the youngest entry.
  always_comb begin
    byp_hit1  = 1'b0;
    byp_hit2  = 1'b0;
    byp_data1 = {DATA_W{1'b0}};
    byp_data2 = {DATA_W{1'b0}};
    idx1_s    = head_r;
    idx2_s    = head_r;
    for (int i = 0; i < DEPTH; i++) begin
      idx1_s = head_r + PW'(i);
      idx2_s = head_r + PW'(i);
      if (valid_r[idx1_s] && (rd_reg1 != 4'd0) && (reg_mem[idx1_s] == rd_reg1)) begin
        byp_hit1  = 1'b1;
        byp_data1 = data_mem[idx1_s];
      end else begin
        byp_hit1  = byp_hit1;
      end
      if (valid_r[idx2_s] && (rd_reg2 != 4'd0) && (reg_mem[idx2_s] == rd_reg2)) begin
        byp_hit2  = 1'b1;
        byp_data2 = data_mem[idx2_s];
      end else begin
        byp_hit2  = byp_hit2;
      end
    end
  end
`else
  logic unused_byp;

  assign byp_hit1   = 1'b0;
  assign byp_hit2   = 1'b0;
  assign byp_data1  = {DATA_W{1'b0}};
  assign byp_data2  = {DATA_W{1'b0}};
  // Read ports and valid bits have no consumer without bypass.
  assign unused_byp = ^{rd_reg1, rd_reg2, valid_r};
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: directed scenarios plus randomized traffic, checked against
// a queue-based reference model of the write-back queue.
module tb_wb_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_reg;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              rf_stall;
  logic              rf_write_en;
  logic [3:0]        rf_write_reg;
  logic [DATA_W-1:0] rf_write_data;
  logic [3:0]        rd_reg1;
  logic [3:0]        rd_reg2;
  logic              byp_hit1;
  logic              byp_hit2;
  logic [DATA_W-1:0] byp_data1;
  logic [DATA_W-1:0] byp_data2;
  logic [2:0]        count;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]        r;
    logic [DATA_W-1:0] d;
  } ent_t;
  ent_t model_q[$];

  wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data), .flush(flush), .rf_stall(rf_stall),
    .rf_write_en(rf_write_en), .rf_write_reg(rf_write_reg),
    .rf_write_data(rf_write_data), .rd_reg1(rd_reg1), .rd_reg2(rd_reg2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1),
    .byp_data2(byp_data2), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Youngest pending entry for a read index, per the bypass rule.
  task automatic model_byp(input logic [3:0] rd, output logic hit, output logic [DATA_W-1:0] data);
    hit  = 1'b0;
    data = '0;
`ifdef WB_BYPASS_EN
    foreach (model_q[k]) begin
      if (rd != 4'd0 && model_q[k].r == rd) begin
        hit  = 1'b1;
        data = model_q[k].d;
      end
    end
`endif
  endtask

  // One clock: drive at negedge, check outputs, then advance model at posedge.
  task automatic step(input logic v, input logic [3:0] r, input logic [DATA_W-1:0] d,
                      input logic fl, input logic st, input logic [3:0] a, input logic [3:0] b);
    logic rdy, wen, h1, h2;
    logic [3:0] ereg;
    logic [DATA_W-1:0] edat, d1, d2;
    @(negedge clk);
    in_valid = v; in_reg = r; in_data = d; flush = fl; rf_stall = st;
    rd_reg1 = a; rd_reg2 = b;
    #1;
    rdy  = (model_q.size() != DEPTH);
    wen  = (model_q.size() != 0) && !st && !fl;
    ereg = wen ? model_q[0].r : 4'd0;
    edat = wen ? model_q[0].d : '0;
    model_byp(a, h1, d1);
    model_byp(b, h2, d2);
    check("in_ready", 32'(in_ready), 32'(rdy));
    check("wen", 32'(rf_write_en), 32'(wen));
    check("wreg", 32'(rf_write_reg), 32'(ereg));
    check("wdata", 32'(rf_write_data), 32'(edat));
    check("count", 32'(count), 32'(model_q.size()));
    check("hit1", 32'(byp_hit1), 32'(h1));
    check("data1", 32'(byp_data1), 32'(d1));
    check("hit2", 32'(byp_hit2), 32'(h2));
    check("data2", 32'(byp_data2), 32'(d2));
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (wen) void'(model_q.pop_front());
      if (v && rdy && r != 4'd0) model_q.push_back('{r: r, d: d});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, '0, 1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_wen"}, 32'(rf_write_en), 32'd0);
    check({tag, "_wreg"}, 32'(rf_write_reg), 32'd0);
    check({tag, "_wdata"}, 32'(rf_write_data), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_hit"}, 32'({byp_hit1, byp_hit2}), 32'd0);
    check({tag, "_bdata"}, 32'({byp_data1, byp_data2}), 32'd0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_reg = 4'd0; in_data = '0; flush = 1'b0;
    rf_stall = 1'b0; rd_reg1 = 4'd3; rd_reg2 = 4'd3;
    #12;
    check_reset_outputs("rst_init");
    @(negedge clk);
    rst = 1'b1;

    // Single push drains the cycle after.
    step(1'b1, 4'd3, 16'h1234, 1'b0, 1'b0, 4'd0, 4'd0);
    #1;
    check("s34_wen", 32'(rf_write_en), 32'd1);
    check("s34_wreg", 32'(rf_write_reg), 32'd3);
    check("s34_wdata", 32'(rf_write_data), 32'h1234);
    idle(1);
    #1;
    check("s34_count", 32'(count), 32'd0);

    // Fill under stall, overflow attempt, then drain in order.
    for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 16'(16'h100 + i), 1'b0, 1'b1, 4'd0, 4'd0);
    #1;
    check("s35_count", 32'(count), 32'd4);
    check("s35_ready", 32'(in_ready), 32'd0);
    step(1'b1, 4'd9, 16'hBEEF, 1'b0, 1'b1, 4'd0, 4'd0);
    idle(4);
    #1;
    check("s35_drained", 32'(count), 32'd0);

    // Register-0 write is dropped.
    step(1'b1, 4'd0, 16'hFFFF, 1'b0, 1'b0, 4'd0, 4'd0);
    idle(2);

    // Bypass picks the youngest of two writes to the same register.
    step(1'b1, 4'd5, 16'h0001, 1'b0, 1'b1, 4'd0, 4'd0);
    step(1'b1, 4'd5, 16'h0002, 1'b0, 1'b1, 4'd0, 4'd0);
    step(1'b0, 4'd0, '0, 1'b0, 1'b1, 4'd5, 4'd0);
`ifdef WB_BYPASS_EN
    #1;
    check("s37_hit1", 32'(byp_hit1), 32'd1);
    check("s37_data1", 32'(byp_data1), 32'h0002);
    check("s37_hit2", 32'(byp_hit2), 32'd0);
`endif
    idle(3);

    // Flush with three pending and a concurrent push.
    for (int i = 0; i < 3; i++) step(1'b1, 4'(6 + i), 16'(16'hA0 + i), 1'b0, 1'b1, 4'd0, 4'd0);
    step(1'b1, 4'd7, 16'h7777, 1'b1, 1'b0, 4'd7, 4'd6);
    #1;
    check("s38_count", 32'(count), 32'd0);
    idle(2);

    // Asynchronous reset between edges with two pending.
    step(1'b1, 4'd2, 16'h2222, 1'b0, 1'b1, 4'd2, 4'd0);
    step(1'b1, 4'd4, 16'h4444, 1'b0, 1'b1, 4'd4, 4'd2);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("s39");
    model_q.delete();
    @(negedge clk);
    in_valid = 1'b0; rf_stall = 1'b0;
    rst = 1'b1;
    idle(3);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 7)), 16'($urandom),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 4),
           4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
